// File: rtl/accum_loop_engine_if.sv
// Sequencer-to-engine bundle: launch request, operands, status and result registers.
interface accum_loop_engine_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       yIn;
  logic [CNT_WIDTH-1:0]   limit;
  logic                   busy;
  logic                   done;
  logic                   overflow;
  logic [CNT_WIDTH:0]     outRegI;
  logic [WIDTH-1:0]       outRegX;
  logic [WIDTH-1:0]       outRegY;

  modport master (
    output start, yIn, limit,
    input  busy, done, overflow, outRegI, outRegX, outRegY
  );

  modport slave (
    input  start, yIn, limit,
    output busy, done, overflow, outRegI, outRegX, outRegY
  );
endinterface

// File: rtl/accum_loop_engine.sv
// Runs x=0; for (i=0; i<=limit; i++) x+=y; then clears y if x<0 else clears x.
// done pulses 2*limit+4 edges after start is taken; start is ignored while busy.
module accum_loop_engine #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  accum_loop_engine_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ACCUM = 3'd2,
    S_CHECK = 3'd3,
    S_CLRY  = 3'd4,
    S_CLRX  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH:0]   i_reg;
  logic [WIDTH-1:0]     x_reg;
  logic [WIDTH-1:0]     y_reg;
  logic [CNT_WIDTH-1:0] lim_reg;
  logic                 ovf_reg;

  logic [WIDTH-1:0]     sum;
  logic                 add_ovf;
  logic                 loop_more;

  assign sum       = x_reg + y_reg;
  // Same-sign operands whose sum flips sign have overflowed in two's complement.
  assign add_ovf   = (x_reg[WIDTH-1] == y_reg[WIDTH-1]) && (sum[WIDTH-1] != x_reg[WIDTH-1]);
  assign loop_more = (i_reg <= {1'b0, lim_reg});

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = bus.start ? S_INIT : S_IDLE;
      S_INIT:  state_nxt = S_ACCUM;
      S_ACCUM: state_nxt = S_CHECK;
      S_CHECK: begin
        if (loop_more)
          state_nxt = S_ACCUM;
        else if (x_reg[WIDTH-1])
          state_nxt = S_CLRY;
        else
          state_nxt = S_CLRX;
      end
      S_CLRY:  state_nxt = S_DONE;
      S_CLRX:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= S_IDLE;
      i_reg   <= '0;
      x_reg   <= '0;
      y_reg   <= '0;
      lim_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_INIT: begin
          i_reg   <= '0;
          x_reg   <= '0;
          y_reg   <= bus.yIn;
          lim_reg <= bus.limit;
          ovf_reg <= 1'b0;
        end
        S_ACCUM: begin
          x_reg   <= sum;
          i_reg   <= i_reg + 1'b1;
          ovf_reg <= ovf_reg | add_ovf;
        end
        S_CLRY:  y_reg <= '0;
        S_CLRX:  x_reg <= '0;
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.overflow = ovf_reg;
  assign bus.outRegI  = i_reg;
  assign bus.outRegX  = x_reg;
  assign bus.outRegY  = y_reg;

endmodule

// File: tb/tb_accum_loop_engine.sv
// Bench for accum_loop_engine: scenario tasks checked against an arithmetic model of the loop.
module tb_accum_loop_engine;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  accum_loop_engine_if #(.WIDTH(8), .CNT_WIDTH(8)) bus ();

  accum_loop_engine #(.WIDTH(8), .CNT_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: plain integer loop, wrap into 8-bit signed range, flag any out-of-range partial sum.
  function automatic void model(input logic [7:0] y, input int lim,
                                output logic [8:0] ei, output logic [7:0] ex,
                                output logic [7:0] ey, output logic eo,
                                output logic [7:0] ex_pre);
    int xs;
    int ys;
    ys = int'($signed(y));
    xs = 0;
    eo = 1'b0;
    for (int k = 0; k <= lim; k++) begin
      xs = xs + ys;
      if (xs > 127) begin
        xs = xs - 256;
        eo = 1'b1;
      end else if (xs < -128) begin
        xs = xs + 256;
        eo = 1'b1;
      end
    end
    ei     = 9'(lim + 1);
    ex_pre = xs[7:0];
    if (xs < 0) begin
      ex = xs[7:0];
      ey = 8'h00;
    end else begin
      ex = 8'h00;
      ey = y;
    end
  endfunction

  task automatic launch(input logic [7:0] y, input int lim);
    @(negedge clock);
    bus.yIn   = y;
    bus.limit = lim[7:0];
    bus.start = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Counts edges after the start edge until done is seen; optionally pokes start/yIn mid-run.
  task automatic wait_done(input int lim, input bit hold, input int poke_at,
                           output int lat, output logic [7:0] xchk);
    lat  = -1;
    xchk = 8'hxx;
    if (!hold) bus.start = 1'b0;
    for (int n = 1; n <= 700; n++) begin
      @(posedge clock);
      #1;
      if (!hold) bus.start = (n == poke_at);
      if (n == poke_at) bus.yIn = ~bus.yIn;
      if (n == 2 * lim + 2) xchk = bus.outRegX;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.yIn   = 8'h55;
    bus.limit = 8'd3;
    reset     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b want busy=0 done=0", bus.busy, bus.done);
    end
    checks++;
    if ({bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow} !== 26'd0) begin
      errors++;
      $display("FAIL reset_regs: got i=%0d x=%h y=%h ovf=%b want all 0",
               bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow);
    end
    bus.start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_single(input string name, input logic [7:0] y, input int lim);
    logic [8:0] ei;
    logic [7:0] ex, ey, exp_pre, xchk;
    logic       eo;
    int         lat;
    model(y, lim, ei, ex, ey, eo, exp_pre);
    launch(y, lim);
    wait_done(lim, 1'b0, 0, lat, xchk);
    checks++;
    if (lat != 2 * lim + 4) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, 2 * lim + 4);
    end
    checks++;
    if (xchk !== exp_pre) begin
      errors++;
      $display("FAIL %s_x_in_check: got %h want %h", name, xchk, exp_pre);
    end
    checks++;
    if ({bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow} !== {ei, ex, ey, eo}) begin
      errors++;
      $display("FAIL %s_regs: got i=%0d x=%h y=%h ovf=%b want i=%0d x=%h y=%h ovf=%b", name,
               bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow, ei, ex, ey, eo);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
        {bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow} !== {ei, ex, ey, eo}) begin
      errors++;
      $display("FAIL %s_hold: got done=%b busy=%b i=%0d x=%h want done=0 busy=0 i=%0d x=%h", name,
               bus.done, bus.busy, bus.outRegI, bus.outRegX, ei, ex);
    end
  endtask

  task automatic test_random();
    logic [8:0] ei;
    logic [7:0] ex, ey, exp_pre, xchk, y;
    logic       eo;
    int         lat, lim;
    for (int r = 0; r < 10; r++) begin
      y   = 8'($urandom);
      lim = int'($urandom_range(0, 20));
      model(y, lim, ei, ex, ey, eo, exp_pre);
      launch(y, lim);
      wait_done(lim, 1'b0, 0, lat, xchk);
      checks++;
      if (lat != 2 * lim + 4 ||
          {bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow} !== {ei, ex, ey, eo}) begin
        errors++;
        $display("FAIL random_%0d: y=%h lim=%0d got lat=%0d i=%0d x=%h y=%h ovf=%b want lat=%0d i=%0d x=%h y=%h ovf=%b",
                 r, y, lim, lat, bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow,
                 2 * lim + 4, ei, ex, ey, eo);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_handshake();
    logic [8:0] ei;
    logic [7:0] ex, ey, exp_pre, xchk;
    logic       eo;
    int         lat, extra;
    model(8'd5, 4, ei, ex, ey, eo, exp_pre);
    launch(8'd5, 4);
    wait_done(4, 1'b0, 3, lat, xchk);
    checks++;
    if (lat != 12 ||
        {bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow} !== {ei, ex, ey, eo}) begin
      errors++;
      $display("FAIL poke_result: got lat=%0d i=%0d x=%h y=%h ovf=%b want lat=12 i=%0d x=%h y=%h ovf=%b",
               lat, bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow, ei, ex, ey, eo);
    end
    extra = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clock);
      #1;
      if (bus.done || bus.busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL poke_single_done: got %0d active cycles after done want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] ei;
    logic [7:0] ex, ey, exp_pre, xchk;
    logic       eo;
    int         lat;
    model(8'd7, 3, ei, ex, ey, eo, exp_pre);
    launch(8'd7, 3);
    wait_done(3, 1'b1, 0, lat, xchk);
    checks++;
    if (lat != 10) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d want 10", lat);
    end
    for (int run = 0; run < 2; run++) begin
      @(posedge clock);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle_gap_%0d: got busy=%b want 0", run, bus.busy);
      end
      @(posedge clock);
      #1;
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_restart_%0d: got busy=%b want 1", run, bus.busy);
      end
      wait_done(3, 1'b1, 0, lat, xchk);
      checks++;
      if (lat != 10 ||
          {bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow} !== {ei, ex, ey, eo}) begin
        errors++;
        $display("FAIL b2b_run_%0d: got lat=%0d i=%0d x=%h want lat=10 i=%0d x=%h",
                 run, lat, bus.outRegI, bus.outRegX, ei, ex);
      end
    end
    bus.start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [8:0] ei;
    logic [7:0] ex, ey, exp_pre, xchk;
    logic       eo;
    int         lat;
    bit         found;
    launch(8'd9, 10);
    bus.start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clock);
      #1;
      if (bus.outRegI == 9'd5) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_reach_i5: got i=%0d want 5", bus.outRegI);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    checks++;
    if ({bus.busy, bus.done, bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow} !== 28'd0) begin
      errors++;
      $display("FAIL midreset_clear: got busy=%b done=%b i=%0d x=%h y=%h ovf=%b want all 0",
               bus.busy, bus.done, bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow);
    end
    model(8'd2, 3, ei, ex, ey, eo, exp_pre);
    launch(8'd2, 3);
    wait_done(3, 1'b0, 0, lat, xchk);
    checks++;
    if (lat != 10 ||
        {bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow} !== {ei, ex, ey, eo}) begin
      errors++;
      $display("FAIL midreset_rerun: got lat=%0d i=%0d x=%h y=%h ovf=%b want lat=10 i=%0d x=%h y=%h ovf=%b",
               lat, bus.outRegI, bus.outRegX, bus.outRegY, bus.overflow, ei, ex, ey, eo);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.yIn   = 8'h00;
    bus.limit = 8'h00;
    test_reset();
    test_single("positive", 8'd3, 10);
    test_single("negative", 8'hFD, 10);
    test_single("overflow", 8'd100, 1);
    test_single("ovf_clear", 8'd1, 0);
    test_single("boundary", 8'd0, 255);
    test_random();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
